multi_book_engine: RTL and testbench
====================================

# multi_book_engine

Parametrised multi-instrument order book engine: consumes decoded add/delete/execute messages, tracks resting orders in a direct-mapped order map, aggregates shares per price level for NUM_BOOKS instruments on both sides, and emits the updated best bid/offer (BBO) of the touched book after every message. It sits between the message decoder and the strategy/market-data fan-out, replacing the single-book engine with multi-book, level-aggregating, handshaked operation.

## Interface
- NUM_BOOKS, 4, number of instruments; valid locate range 0..NUM_BOOKS-1
- ORDER_MAP_DEPTH, 256, order map entries; power of two
- BOOK_LEVELS, 8, price-level slots per book per side
- clkIn  in  1  single clock, all logic rising-edge
- rstIn  in  1  synchronous, active-high reset
- validIn  in  1  message valid
- readyOut  out  1  engine can accept; transfer when validIn && readyOut
- msgTypeIn  in  2  0=add, 1=delete, 2=execute, 3=reserved
- refNumIn  in  64  order reference number
- locateIn  in  16  book index (add only; del/exec use stored value)
- priceIn  in  32  price (add only)
- sharesIn  in  32  add: shares; execute: executed shares
- buySellIn  in  1  1=buy, 0=sell (add only)
- bboValidOut  out  1  one-cycle pulse, BBO outputs valid
- bboLocateOut  out  16  book updated
- bidValidOut / askValidOut  out  1  side non-empty
- bidPriceOut / askPriceOut  out  32  best price (0 when side empty)
- bidSharesOut / askSharesOut  out  32  aggregate shares at best price (0 when empty)
- errValidOut  out  1  one-cycle pulse, message rejected
- errCodeOut  out  3  1=add collision, 2=del/exec miss, 3=level table full, 4=locate out of range, 5=reserved type, 6=level share overflow

## Operation
- Order map entry: {valid, refNum[63:0], locate, price, shares, side}; index = refNum[log2(ORDER_MAP_DEPTH)-1:0]. Valid bits in flops; payload may be RAM with 1-cycle read.
- Level slot: {valid, price, shares}; per (book, side).
- FSM: IDLE -> LOOKUP -> UPDATE -> EMIT -> IDLE. readyOut = (state==IDLE). Message captured into registers on acceptance.
- LOOKUP: read map entry at index; hit = valid && stored refNum == refNumIn; search level slots of target (book, side) for matching price and first free slot (lowest index).
- UPDATE, add: error 1 if map slot valid (any refNum); error 4 if locateIn >= NUM_BOOKS; else merge into matching level (error 6 if sum exceeds 2^32-1) or allocate lowest free slot (error 3 if none); on success write map entry.
- UPDATE, delete: miss -> error 2; hit -> subtract stored shares from level, clear map valid.
- UPDATE, execute: miss -> error 2; delta = min(sharesIn, stored shares); subtract from level and entry; entry cleared when remaining shares reach 0. sharesIn=0 is a successful no-op.
- Level slot whose shares reach 0 is freed in the same update.
- Any error: no map or level state changes.
- EMIT: success -> bboValidOut=1 with BBO of touched book: bid = max price over valid bid slots, ask = min price over valid ask slots. Error -> errValidOut=1, errCodeOut set, bboValidOut=0. For errors 1/4/5 bboLocateOut is don't-care.

## Timing
- Accept at edge T; LOOKUP in cycle after T; UPDATE after T+1; EMIT after T+2 (outputs high exactly that cycle); IDLE/readyOut high after T+3. Max one message per 4 cycles.
- readyOut independent of validIn; message held by source until accepted.
- All outputs registered; reset values: readyOut=1 after the reset cycle (0 while rstIn high), all other outputs 0.
- Reset mid-operation: in-flight message dropped, no pulse emitted, FSM to IDLE, all map and level valid bits cleared in one cycle.
- Back-to-back messages to the same refNum are safe: the earlier update is complete before the next LOOKUP.

## Configuration
- MULTI_BOOK_ENGINE_STATS_EN defined: adds outputs msgCountOut[31:0] (accepted messages) and errCountOut[31:0] (rejected messages), wrapping counters, cleared by rstIn.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Add ref=5, locate=1, buy, price=100, shares=50 -> EMIT cycle 3 after accept: bboLocateOut=1, bidValid=1, bid=100/50, askValid=0.
- Then add ref=6 book 1 buy 100/25 and ref=7 buy 101/10 -> bid 100/75 then bid 101/10; delete ref=7 -> bid 100/75.
- Execute ref=5 sharesIn=80 -> clamped to 50, bid 100/25; delete ref=5 -> error 2 (miss).
- Add with ref colliding on map index (ref=5 and ref=5+ORDER_MAP_DEPTH) -> second returns error 1, book unchanged; add with locate=NUM_BOOKS -> error 4; msgType=3 -> error 5.
- Fill BOOK_LEVELS distinct ask prices in book 0, add one more new price -> error 3; add at existing price merges successfully.
- Assert rstIn during UPDATE -> no bbo/err pulse, readyOut=1 the cycle after reset; delete of previously added ref -> error 2.

Source files
------------

// File: rtl/multi_book_engine_if.sv
// Message-in / BBO-out bundle for multi_book_engine.
// master = message source and BBO consumer; slave = engine.
interface multi_book_engine_if;
  logic        validIn;
  logic        readyOut;
  logic [1:0]  msgTypeIn;
  logic [63:0] refNumIn;
  logic [15:0] locateIn;
  logic [31:0] priceIn;
  logic [31:0] sharesIn;
  logic        buySellIn;
  logic        bboValidOut;
  logic [15:0] bboLocateOut;
  logic        bidValidOut;
  logic        askValidOut;
  logic [31:0] bidPriceOut;
  logic [31:0] askPriceOut;
  logic [31:0] bidSharesOut;
  logic [31:0] askSharesOut;
  logic        errValidOut;
  logic [2:0]  errCodeOut;

  modport master (
    output validIn, msgTypeIn, refNumIn, locateIn, priceIn, sharesIn, buySellIn,
    input  readyOut, bboValidOut, bboLocateOut, bidValidOut, askValidOut,
    input  bidPriceOut, askPriceOut, bidSharesOut, askSharesOut, errValidOut, errCodeOut
  );

  modport slave (
    input  validIn, msgTypeIn, refNumIn, locateIn, priceIn, sharesIn, buySellIn,
    output readyOut, bboValidOut, bboLocateOut, bidValidOut, askValidOut,
    output bidPriceOut, askPriceOut, bidSharesOut, askSharesOut, errValidOut, errCodeOut
  );
endinterface

// File: rtl/multi_book_engine.sv
// Multi-instrument, level-aggregating order book engine emitting the BBO of the touched book per message.
// Optional MULTI_BOOK_ENGINE_STATS_EN adds accepted/rejected message counters.
module multi_book_engine #(
  parameter int unsigned NUM_BOOKS       = 4,
  parameter int unsigned ORDER_MAP_DEPTH = 256,
  parameter int unsigned BOOK_LEVELS     = 8
) (
  input  logic               clkIn,
  input  logic               rstIn,
  multi_book_engine_if.slave bus
`ifdef MULTI_BOOK_ENGINE_STATS_EN
  ,
  output logic [31:0]        msgCountOut,
  output logic [31:0]        errCountOut
`endif
);
  localparam int unsigned IW    = (ORDER_MAP_DEPTH > 1) ? $clog2(ORDER_MAP_DEPTH) : 1;
  localparam int unsigned BW    = (NUM_BOOKS > 1) ? $clog2(NUM_BOOKS) : 1;
  localparam int unsigned LW    = (BOOK_LEVELS > 1) ? $clog2(BOOK_LEVELS) : 1;
  localparam int unsigned NSLOT = NUM_BOOKS * 2 * BOOK_LEVELS;
  localparam int unsigned SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_EMIT} state_t;
  state_t r_state, w_next;

  logic        r_ready;
  logic [1:0]  r_type;
  logic [63:0] r_ref;
  logic [15:0] r_loc;
  logic [31:0] r_price, r_shares;
  logic        r_side;

  logic [ORDER_MAP_DEPTH-1:0] r_mapValid;
  logic [63:0] r_mapRef    [ORDER_MAP_DEPTH];
  logic [15:0] r_mapLoc    [ORDER_MAP_DEPTH];
  logic [31:0] r_mapPrice  [ORDER_MAP_DEPTH];
  logic [31:0] r_mapShares [ORDER_MAP_DEPTH];
  logic        r_mapSide   [ORDER_MAP_DEPTH];
  logic        r_mValid, r_hit, r_mSide;
  logic [15:0] r_mLoc;
  logic [31:0] r_mPrice, r_mShares;

  logic [NSLOT-1:0] r_lvValid;
  logic [31:0] r_lvPrice  [NSLOT];
  logic [31:0] r_lvShares [NSLOT];

  logic        r_bboValid, r_errValid, r_bidValid, r_askValid;
  logic [2:0]  r_errCode;
  logic [15:0] r_bboLoc;
  logic [31:0] r_bidPrice, r_bidShares, r_askPrice, r_askShares;

  logic          w_accept, w_isAdd, w_locOk, w_side, w_found, w_hasFree;
  logic [IW-1:0] w_idx;
  logic [BW-1:0] w_book;
  logic [31:0]   w_px, w_curShares, w_delta, w_mapNewShares, w_lvNewShares;
  logic [15:0]   w_bboLoc;
  logic [SW-1:0] w_tgtBase, w_slot, w_matchSlot, w_freeSlot, w_lvSlot;
  logic [LW-1:0] w_matchIdx, w_freeIdx;
  logic [32:0]   w_sum;
  logic          w_err, w_lvWrite, w_lvNewValid, w_mapAdd, w_mapDel, w_mapExec;
  logic [2:0]    w_code;
  logic [SW-1:0] w_bidBase, w_askBase, w_bSlot, w_aSlot;
  logic          w_bV, w_aV, w_bidValid, w_askValid;
  logic [31:0]   w_bP, w_bS, w_aP, w_aS, w_bidPrice, w_bidShares, w_askPrice, w_askShares;

  assign w_accept = bus.validIn && r_ready;
  assign w_idx    = r_ref[IW-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: w_next = S_UPDATE;
      S_UPDATE: w_next = S_EMIT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Add targets the captured locate/side; delete/execute target what the map entry recorded.
  always_comb begin
    w_isAdd  = (r_type == 2'd0);
    w_locOk  = (32'(r_loc) < NUM_BOOKS);
    w_book   = '0;
    if (!w_isAdd)     w_book = r_mLoc[BW-1:0];
    else if (w_locOk) w_book = r_loc[BW-1:0];
    w_side    = w_isAdd ? r_side  : r_mSide;
    w_px      = w_isAdd ? r_price : r_mPrice;
    w_bboLoc  = w_isAdd ? r_loc   : r_mLoc;
    w_tgtBase = SW'({w_book, w_side} * BOOK_LEVELS);
    w_found   = 1'b0;
    w_hasFree = 1'b0;
    w_matchIdx = '0;
    w_freeIdx  = '0;
    w_slot     = '0;
    for (int unsigned j = 0; j < BOOK_LEVELS; j++) begin
      w_slot = w_tgtBase + SW'(j);
      if (r_lvValid[w_slot] && (r_lvPrice[w_slot] == w_px) && !w_found) begin
        w_found    = 1'b1;
        w_matchIdx = LW'(j);
      end
      if (!r_lvValid[w_slot] && !w_hasFree) begin
        w_hasFree = 1'b1;
        w_freeIdx = LW'(j);
      end
    end
    w_matchSlot    = w_tgtBase + SW'(w_matchIdx);
    w_freeSlot     = w_tgtBase + SW'(w_freeIdx);
    w_curShares    = r_lvShares[w_matchSlot];
    w_sum          = {1'b0, w_curShares} + {1'b0, r_shares};
    w_delta        = (r_shares < r_mShares) ? r_shares : r_mShares;
    w_mapNewShares = r_mShares - w_delta;
    w_err          = 1'b0;
    w_code         = '0;
    w_lvWrite      = 1'b0;
    w_lvSlot       = w_matchSlot;
    w_lvNewShares  = w_curShares;
    w_mapAdd       = 1'b0;
    w_mapDel       = 1'b0;
    w_mapExec      = 1'b0;
    case (r_type)
      2'd0: begin
        if (r_mValid)         begin w_err = 1'b1; w_code = 3'd1; end
        else if (!w_locOk)    begin w_err = 1'b1; w_code = 3'd4; end
        else if (w_found) begin
          if (w_sum[32])      begin w_err = 1'b1; w_code = 3'd6; end
          else begin w_lvWrite = 1'b1; w_lvNewShares = w_sum[31:0]; w_mapAdd = 1'b1; end
        end
        else if (!w_hasFree)  begin w_err = 1'b1; w_code = 3'd3; end
        else begin
          w_lvWrite = 1'b1; w_lvSlot = w_freeSlot; w_lvNewShares = r_shares; w_mapAdd = 1'b1;
        end
      end
      2'd1: begin
        if (!r_hit) begin w_err = 1'b1; w_code = 3'd2; end
        else begin w_lvWrite = w_found; w_lvNewShares = w_curShares - r_mShares; w_mapDel = 1'b1; end
      end
      2'd2: begin
        if (!r_hit) begin w_err = 1'b1; w_code = 3'd2; end
        else begin w_lvWrite = w_found; w_lvNewShares = w_curShares - w_delta; w_mapExec = 1'b1; end
      end
      default: begin w_err = 1'b1; w_code = 3'd5; end
    endcase
    w_lvNewValid = (w_lvNewShares != '0);
  end

  // BBO is taken over the level table as it will look after this update's write.
  always_comb begin
    w_bidBase   = SW'({w_book, 1'b1} * BOOK_LEVELS);
    w_askBase   = SW'({w_book, 1'b0} * BOOK_LEVELS);
    w_bidValid  = 1'b0; w_bidPrice = '0; w_bidShares = '0;
    w_askValid  = 1'b0; w_askPrice = '0; w_askShares = '0;
    w_bSlot = '0; w_bV = 1'b0; w_bP = '0; w_bS = '0;
    w_aSlot = '0; w_aV = 1'b0; w_aP = '0; w_aS = '0;
    for (int unsigned j = 0; j < BOOK_LEVELS; j++) begin
      w_bSlot = w_bidBase + SW'(j);
      w_bV = r_lvValid[w_bSlot]; w_bP = r_lvPrice[w_bSlot]; w_bS = r_lvShares[w_bSlot];
      if (w_lvWrite && (w_bSlot == w_lvSlot)) begin w_bV = w_lvNewValid; w_bP = w_px; w_bS = w_lvNewShares; end
      if (w_bV && (!w_bidValid || (w_bP > w_bidPrice))) begin
        w_bidValid = 1'b1; w_bidPrice = w_bP; w_bidShares = w_bS;
      end
      w_aSlot = w_askBase + SW'(j);
      w_aV = r_lvValid[w_aSlot]; w_aP = r_lvPrice[w_aSlot]; w_aS = r_lvShares[w_aSlot];
      if (w_lvWrite && (w_aSlot == w_lvSlot)) begin w_aV = w_lvNewValid; w_aP = w_px; w_aS = w_lvNewShares; end
      if (w_aV && (!w_askValid || (w_aP < w_askPrice))) begin
        w_askValid = 1'b1; w_askPrice = w_aP; w_askShares = w_aS;
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_mapValid <= '0;
      r_lvValid  <= '0;
      r_mValid   <= 1'b0;
      r_hit      <= 1'b0;
      r_type     <= '0;  r_ref <= '0; r_loc <= '0; r_price <= '0; r_shares <= '0; r_side <= 1'b0;
      r_bboValid <= 1'b0; r_errValid <= 1'b0; r_errCode <= '0; r_bboLoc <= '0;
      r_bidValid <= 1'b0; r_bidPrice <= '0; r_bidShares <= '0;
      r_askValid <= 1'b0; r_askPrice <= '0; r_askShares <= '0;
    end else begin
      r_state    <= w_next;
      r_ready    <= (w_next == S_IDLE);
      r_bboValid <= 1'b0;
      r_errValid <= 1'b0;
      if (w_accept) begin
        r_type  <= bus.msgTypeIn; r_ref <= bus.refNumIn; r_loc <= bus.locateIn;
        r_price <= bus.priceIn;   r_shares <= bus.sharesIn; r_side <= bus.buySellIn;
      end
      if (r_state == S_LOOKUP) begin
        r_mValid <= r_mapValid[w_idx];
        r_hit    <= r_mapValid[w_idx] && (r_mapRef[w_idx] == r_ref);
      end
      if (r_state == S_UPDATE) begin
        if (w_err) begin
          r_errValid <= 1'b1;
          r_errCode  <= w_code;
        end else begin
          r_bboValid <= 1'b1; r_bboLoc <= w_bboLoc;
          r_bidValid <= w_bidValid; r_bidPrice <= w_bidPrice; r_bidShares <= w_bidShares;
          r_askValid <= w_askValid; r_askPrice <= w_askPrice; r_askShares <= w_askShares;
          if (w_lvWrite) r_lvValid[w_lvSlot] <= w_lvNewValid;
          if (w_mapAdd)  r_mapValid[w_idx] <= 1'b1;
          if (w_mapDel || (w_mapExec && (w_mapNewShares == '0))) r_mapValid[w_idx] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (r_state == S_LOOKUP) begin
      r_mLoc <= r_mapLoc[w_idx]; r_mPrice <= r_mapPrice[w_idx];
      r_mShares <= r_mapShares[w_idx]; r_mSide <= r_mapSide[w_idx];
    end
    if (!rstIn && (r_state == S_UPDATE) && !w_err) begin
      if (w_mapAdd) begin
        r_mapRef[w_idx] <= r_ref; r_mapLoc[w_idx] <= r_loc; r_mapPrice[w_idx] <= r_price;
        r_mapShares[w_idx] <= r_shares; r_mapSide[w_idx] <= r_side;
      end
      if (w_mapExec) r_mapShares[w_idx] <= w_mapNewShares;
      if (w_lvWrite) begin
        r_lvPrice[w_lvSlot]  <= w_px;
        r_lvShares[w_lvSlot] <= w_lvNewShares;
      end
    end
  end

`ifdef MULTI_BOOK_ENGINE_STATS_EN
  logic [31:0] r_msgCount, r_errCount;
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_msgCount <= '0;
      r_errCount <= '0;
    end else begin
      if (w_accept) r_msgCount <= r_msgCount + 32'd1;
      if ((r_state == S_UPDATE) && w_err) r_errCount <= r_errCount + 32'd1;
    end
  end
  assign msgCountOut = r_msgCount;
  assign errCountOut = r_errCount;
`endif

  assign bus.readyOut     = r_ready;
  assign bus.bboValidOut  = r_bboValid;
  assign bus.bboLocateOut = r_bboLoc;
  assign bus.bidValidOut  = r_bidValid;
  assign bus.bidPriceOut  = r_bidPrice;
  assign bus.bidSharesOut = r_bidShares;
  assign bus.askValidOut  = r_askValid;
  assign bus.askPriceOut  = r_askPrice;
  assign bus.askSharesOut = r_askShares;
  assign bus.errValidOut  = r_errValid;
  assign bus.errCodeOut   = r_errCode;
endmodule

// File: tb/tb_multi_book_engine.sv
// Directed testbench for multi_book_engine: hand-computed BBO and error expectations.
module tb_multi_book_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_book_engine_if bus ();
`ifdef MULTI_BOOK_ENGINE_STATS_EN
  logic [31:0] msgCount, errCount;
`endif

  multi_book_engine #(.NUM_BOOKS(4), .ORDER_MAP_DEPTH(256), .BOOK_LEVELS(8)) dut (
    .clkIn (clk),
    .rstIn (rst),
    .bus   (bus)
`ifdef MULTI_BOOK_ENGINE_STATS_EN
    ,
    .msgCountOut (msgCount),
    .errCountOut (errCount)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [147:0] c_bbo, exp_b;
  logic [4:0]   c_errv, exp_e;
  logic [1:0]   c_mid;
  logic [2:0]   c_after;

  function automatic logic [147:0] bbo_exp(input logic [15:0] loc, input logic bv,
      input logic [31:0] bp, input logic [31:0] bs, input logic av,
      input logic [31:0] ap, input logic [31:0] as_);
    return {1'b1, 1'b0, loc, bv, bp, bs, av, ap, as_};
  endfunction

  task automatic drive(input logic [1:0] t, input logic [63:0] rf, input logic [15:0] lc,
                       input logic [31:0] px, input logic [31:0] sh, input logic bs);
    int unsigned k = 0;
    @(negedge clk);
    while (bus.readyOut !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout got %b want 1", bus.readyOut);
    end
    bus.msgTypeIn = t; bus.refNumIn = rf; bus.locateIn = lc;
    bus.priceIn = px; bus.sharesIn = sh; bus.buySellIn = bs;
    bus.validIn = 1'b1;
    @(posedge clk);
    #1 bus.validIn = 1'b0;
  endtask

  task automatic do_msg(input logic [1:0] t, input logic [63:0] rf, input logic [15:0] lc,
                        input logic [31:0] px, input logic [31:0] sh, input logic bs);
    drive(t, rf, lc, px, sh, bs);
    @(posedge clk); #1 c_mid = {bus.bboValidOut, bus.errValidOut};
    @(posedge clk); #1;
    c_bbo  = {bus.bboValidOut, bus.errValidOut, bus.bboLocateOut,
              bus.bidValidOut, bus.bidPriceOut, bus.bidSharesOut,
              bus.askValidOut, bus.askPriceOut, bus.askSharesOut};
    c_errv = {bus.bboValidOut, bus.errValidOut, bus.errCodeOut};
    @(posedge clk); #1 c_after = {bus.bboValidOut, bus.errValidOut, bus.readyOut};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.readyOut, bus.bboValidOut, bus.errValidOut, bus.errCodeOut, bus.bboLocateOut,
         bus.bidValidOut, bus.bidPriceOut, bus.bidSharesOut,
         bus.askValidOut, bus.askPriceOut, bus.askSharesOut} !== '0) begin
      n_err++; $display("FAIL reset_outputs got nonzero outputs want all 0 (ready=%b)", bus.readyOut);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.readyOut !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.readyOut); end
  endtask

  task automatic test_add_basic;
    do_msg(2'd0, 64'd5, 16'd1, 32'd100, 32'd50, 1'b1);
    exp_b = bbo_exp(16'd1, 1'b1, 32'd100, 32'd50, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL add_ref5 got %h want %h", c_bbo, exp_b); end
    n_vec++; if (c_mid !== 2'b00) begin n_err++; $display("FAIL early_pulse got %b want 00", c_mid); end
    n_vec++; if (c_after !== 3'b001) begin n_err++; $display("FAIL pulse_end got %b want 001", c_after); end
  endtask

  task automatic test_levels;
    do_msg(2'd0, 64'd6, 16'd1, 32'd100, 32'd25, 1'b1);
    exp_b = bbo_exp(16'd1, 1'b1, 32'd100, 32'd75, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL merge_ref6 got %h want %h", c_bbo, exp_b); end
    do_msg(2'd0, 64'd7, 16'd1, 32'd101, 32'd10, 1'b1);
    exp_b = bbo_exp(16'd1, 1'b1, 32'd101, 32'd10, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL better_bid got %h want %h", c_bbo, exp_b); end
    do_msg(2'd1, 64'd7, 16'd0, 32'd0, 32'd0, 1'b0);
    exp_b = bbo_exp(16'd1, 1'b1, 32'd100, 32'd75, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL delete_ref7 got %h want %h", c_bbo, exp_b); end
  endtask

  task automatic test_execute;
    do_msg(2'd2, 64'd5, 16'd0, 32'd0, 32'd80, 1'b0);
    exp_b = bbo_exp(16'd1, 1'b1, 32'd100, 32'd25, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL exec_clamp got %h want %h", c_bbo, exp_b); end
    do_msg(2'd1, 64'd5, 16'd0, 32'd0, 32'd0, 1'b0);
    exp_e = {1'b0, 1'b1, 3'd2};
    n_vec++; if (c_errv !== exp_e) begin n_err++; $display("FAIL del_after_exec got %b want %b", c_errv, exp_e); end
    do_msg(2'd2, 64'd6, 16'd0, 32'd0, 32'd0, 1'b0);
    exp_b = bbo_exp(16'd1, 1'b1, 32'd100, 32'd25, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL exec_zero got %h want %h", c_bbo, exp_b); end
  endtask

  task automatic test_errors;
    do_msg(2'd0, 64'd262, 16'd1, 32'd99, 32'd1, 1'b1);
    exp_e = {1'b0, 1'b1, 3'd1};
    n_vec++; if (c_errv !== exp_e) begin n_err++; $display("FAIL collision got %b want %b", c_errv, exp_e); end
    do_msg(2'd0, 64'd8, 16'd1, 32'd105, 32'd5, 1'b0);
    exp_b = bbo_exp(16'd1, 1'b1, 32'd100, 32'd25, 1'b1, 32'd105, 32'd5);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL book_unchanged got %h want %h", c_bbo, exp_b); end
    do_msg(2'd1, 64'd262, 16'd0, 32'd0, 32'd0, 1'b0);
    exp_e = {1'b0, 1'b1, 3'd2};
    n_vec++; if (c_errv !== exp_e) begin n_err++; $display("FAIL ref_mismatch got %b want %b", c_errv, exp_e); end
    do_msg(2'd0, 64'd9, 16'd4, 32'd10, 32'd1, 1'b1);
    exp_e = {1'b0, 1'b1, 3'd4};
    n_vec++; if (c_errv !== exp_e) begin n_err++; $display("FAIL locate_range got %b want %b", c_errv, exp_e); end
    do_msg(2'd3, 64'd11, 16'd0, 32'd10, 32'd1, 1'b1);
    exp_e = {1'b0, 1'b1, 3'd5};
    n_vec++; if (c_errv !== exp_e) begin n_err++; $display("FAIL reserved_type got %b want %b", c_errv, exp_e); end
  endtask

  task automatic test_level_full;
    for (int i = 0; i < 8; i++) begin
      do_msg(2'd0, 64'(20 + i), 16'd0, 32'(200 + i), 32'd10, 1'b0);
      exp_b = bbo_exp(16'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd200, 32'd10);
      n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL fill_%0d got %h want %h", i, c_bbo, exp_b); end
    end
    do_msg(2'd0, 64'd28, 16'd0, 32'd208, 32'd10, 1'b0);
    exp_e = {1'b0, 1'b1, 3'd3};
    n_vec++; if (c_errv !== exp_e) begin n_err++; $display("FAIL table_full got %b want %b", c_errv, exp_e); end
    do_msg(2'd0, 64'd29, 16'd0, 32'd203, 32'd5, 1'b0);
    exp_b = bbo_exp(16'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd200, 32'd10);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL full_merge got %h want %h", c_bbo, exp_b); end
    do_msg(2'd0, 64'd30, 16'd0, 32'd201, 32'hFFFF_FFFF, 1'b0);
    exp_e = {1'b0, 1'b1, 3'd6};
    n_vec++; if (c_errv !== exp_e) begin n_err++; $display("FAIL share_overflow got %b want %b", c_errv, exp_e); end
    do_msg(2'd1, 64'd20, 16'd0, 32'd0, 32'd0, 1'b0);
    exp_b = bbo_exp(16'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd201, 32'd10);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL free_best got %h want %h", c_bbo, exp_b); end
    do_msg(2'd0, 64'd28, 16'd0, 32'd208, 32'd10, 1'b0);
    exp_b = bbo_exp(16'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd201, 32'd10);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL reuse_slot got %h want %h", c_bbo, exp_b); end
  endtask

  task automatic test_back_to_back;
    do_msg(2'd0, 64'd40, 16'd2, 32'd50, 32'd7, 1'b1);
    exp_b = bbo_exp(16'd2, 1'b1, 32'd50, 32'd7, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL b2b_add got %h want %h", c_bbo, exp_b); end
    do_msg(2'd2, 64'd40, 16'd0, 32'd0, 32'd7, 1'b0);
    exp_b = bbo_exp(16'd2, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL b2b_exec_all got %h want %h", c_bbo, exp_b); end
    do_msg(2'd0, 64'd40, 16'd2, 32'd55, 32'd3, 1'b0);
    exp_b = bbo_exp(16'd2, 1'b0, 32'd0, 32'd0, 1'b1, 32'd55, 32'd3);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL b2b_readd got %h want %h", c_bbo, exp_b); end
  endtask

  task automatic test_reset_mid;
    drive(2'd0, 64'd12, 16'd1, 32'd90, 32'd3, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.bboValidOut, bus.errValidOut, bus.readyOut} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_pulse got %b want 000", {bus.bboValidOut, bus.errValidOut, bus.readyOut});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.bboValidOut, bus.errValidOut, bus.readyOut} !== 3'b001) begin
      n_err++; $display("FAIL rst_mid_ready got %b want 001", {bus.bboValidOut, bus.errValidOut, bus.readyOut});
    end
    do_msg(2'd1, 64'd6, 16'd0, 32'd0, 32'd0, 1'b0);
    exp_e = {1'b0, 1'b1, 3'd2};
    n_vec++; if (c_errv !== exp_e) begin n_err++; $display("FAIL map_cleared got %b want %b", c_errv, exp_e); end
    do_msg(2'd0, 64'd10, 16'd1, 32'd90, 32'd3, 1'b1);
    exp_b = bbo_exp(16'd1, 1'b1, 32'd90, 32'd3, 1'b0, 32'd0, 32'd0);
    n_vec++; if (c_bbo !== exp_b) begin n_err++; $display("FAIL levels_cleared got %h want %h", c_bbo, exp_b); end
  endtask

  initial begin
    bus.validIn = 1'b0; bus.msgTypeIn = '0; bus.refNumIn = '0; bus.locateIn = '0;
    bus.priceIn = '0; bus.sharesIn = '0; bus.buySellIn = 1'b0;
    test_reset();
    test_add_basic();
    test_levels();
    test_execute();
    test_errors();
    test_level_full();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
